// File: rtl/multi7_scan.sv
// rtl/multi7_scan.sv - multiplexed seven-segment scanner with PWM, LZ blanking and shadow load
//
// Ports:
//   i_clk_10mhz       system clock
//   i_rst_n           synchronous active-low reset
//   i_digits          nibble i drives digit i (digit 0 rightmost)
//   i_dp              decimal point per digit
//   i_hex             1: glyphs A-F for codes 10-15, 0: those codes show no segments
//   i_lz_blank        leading-zero blanking enable
//   i_brightness      frame-rate PWM duty, 0 dark, all-ones always on
//   i_load            capture all data inputs this cycle
//   o_segments_drive  active-high segments, bit6=a .. bit0=g
//   o_dp_drive        active-high decimal point
//   o_displays_neg    active-low digit enables
//   o_frame_start     one-cycle pulse at tick 0 of slot 0
module multi7_scan #(
    parameter int DIGITS      = 4,
    parameter int DELAY       = 10,
    parameter int BLANK       = 2,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                     i_clk_10mhz,
    input  logic                     i_rst_n,
    input  logic [DIGITS*4-1:0]      i_digits,
    input  logic [DIGITS-1:0]        i_dp,
    input  logic                     i_hex,
    input  logic                     i_lz_blank,
    input  logic [BRIGHT_BITS-1:0]   i_brightness,
    input  logic                     i_load,
    output logic [6:0]               o_segments_drive,
    output logic                     o_dp_drive,
    output logic [DIGITS-1:0]        o_displays_neg,
    output logic                     o_frame_start
);

    localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int SW = $clog2(DIGITS);

    localparam logic [TW-1:0]          TICK_LAST   = TW'(DELAY - 1);
    localparam logic [SW-1:0]          SLOT_LAST   = SW'(DIGITS - 1);
    localparam logic [TW-1:0]          BLANK_T     = TW'(BLANK);
    localparam logic [BRIGHT_BITS-1:0] BRIGHT_FULL = '1;

    logic [TW-1:0]          tick, tick_n;
    logic [SW-1:0]          slot, slot_n;
    logic [BRIGHT_BITS-1:0] pwm, pwm_n;
    logic                   frame_end;

    logic [DIGITS*4-1:0]    act_digits, act_digits_n, pend_digits;
    logic [DIGITS-1:0]      act_dp, act_dp_n, pend_dp;
    logic                   act_hex, act_hex_n, pend_hex;
    logic                   act_lz, act_lz_n, pend_lz;
    logic [BRIGHT_BITS-1:0] act_bright, act_bright_n, pend_bright;
    logic                   pend_flag;

    logic [DIGITS-1:0]      blank_n;
    logic                   zero_above;
    logic [3:0]             cur_code;
    logic                   cur_dp;
    logic                   cur_blank;
    logic                   lit_n;
    logic                   en_n;
    logic [DIGITS-1:0]      displays_neg_n;
    logic [6:0]             segments_n;
    logic                   dp_n;
    logic                   frame_start_n;

    function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        if (code > 4'd9 && !hex) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    // Everything below works on next-state values so the registered outputs
    // line up with the counters in the same cycle instead of lagging by one.
    always_comb begin
        frame_end = (tick == TICK_LAST) && (slot == SLOT_LAST);
        tick_n    = tick;
        slot_n    = slot;
        pwm_n     = pwm;
        if (tick == TICK_LAST) begin
            tick_n = '0;
            slot_n = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        end else begin
            tick_n = tick + TW'(1);
        end
        if (frame_end) begin
            pwm_n = pwm + BRIGHT_BITS'(1);
        end

        // Active data only moves at the frame boundary; a load arriving on
        // that very edge bypasses the shadow copy.
        act_digits_n = act_digits;
        act_dp_n     = act_dp;
        act_hex_n    = act_hex;
        act_lz_n     = act_lz;
        act_bright_n = act_bright;
        if (frame_end) begin
            if (i_load) begin
                act_digits_n = i_digits;
                act_dp_n     = i_dp;
                act_hex_n    = i_hex;
                act_lz_n     = i_lz_blank;
                act_bright_n = i_brightness;
            end else if (pend_flag) begin
                act_digits_n = pend_digits;
                act_dp_n     = pend_dp;
                act_hex_n    = pend_hex;
                act_lz_n     = pend_lz;
                act_bright_n = pend_bright;
            end
        end

        // Walk from the most significant digit down; a digit is blanked while
        // it and everything above it is zero. Digit 0 always shows.
        blank_n    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_digits_n[i*4 +: 4] == 4'd0);
            blank_n[i] = act_lz_n && (i != 0) && zero_above;
        end

        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot_n == SW'(i)) begin
                cur_code  = act_digits_n[i*4 +: 4];
                cur_dp    = act_dp_n[i];
                cur_blank = blank_n[i];
            end
        end

        lit_n = (act_bright_n == BRIGHT_FULL) || (pwm_n < act_bright_n);
        en_n  = lit_n && (tick_n >= BLANK_T) && !cur_blank;

        displays_neg_n = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (en_n && (slot_n == SW'(i))) begin
                displays_neg_n[i] = 1'b0;
            end
        end
        segments_n    = en_n ? glyph(cur_code, act_hex_n) : 7'b0000000;
        dp_n          = en_n && cur_dp;
        frame_start_n = (tick_n == '0) && (slot_n == '0);
    end

    always_ff @(posedge i_clk_10mhz) begin
        if (!i_rst_n) begin
            tick             <= TICK_LAST;
            slot             <= SLOT_LAST;
            pwm              <= '1;
            act_digits       <= '0;
            act_dp           <= '0;
            act_hex          <= 1'b0;
            act_lz           <= 1'b0;
            act_bright       <= '0;
            pend_digits      <= '0;
            pend_dp          <= '0;
            pend_hex         <= 1'b0;
            pend_lz          <= 1'b0;
            pend_bright      <= '0;
            pend_flag        <= 1'b0;
            o_displays_neg   <= '1;
            o_segments_drive <= '0;
            o_dp_drive       <= 1'b0;
            o_frame_start    <= 1'b0;
        end else begin
            tick       <= tick_n;
            slot       <= slot_n;
            pwm        <= pwm_n;
            act_digits <= act_digits_n;
            act_dp     <= act_dp_n;
            act_hex    <= act_hex_n;
            act_lz     <= act_lz_n;
            act_bright <= act_bright_n;
            if (i_load) begin
                pend_digits <= i_digits;
                pend_dp     <= i_dp;
                pend_hex    <= i_hex;
                pend_lz     <= i_lz_blank;
                pend_bright <= i_brightness;
            end
            pend_flag        <= frame_end ? 1'b0 : (pend_flag || i_load);
            o_displays_neg   <= displays_neg_n;
            o_segments_drive <= segments_n;
            o_dp_drive       <= dp_n;
            o_frame_start    <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_multi7_scan.sv
// tb/tb_multi7_scan.sv - self-checking bench for multi7_scan
`timescale 1ns/1ps
module tb_multi7_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        hex;
    logic        lz;
    logic [3:0]  bright;
    logic        load;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  neg;
    logic        fs;

    int checks = 0;
    int errors = 0;

    multi7_scan #(.DIGITS(4), .DELAY(10), .BLANK(2), .BRIGHT_BITS(4)) dut (
        .i_clk_10mhz      (clk),
        .i_rst_n          (rst_n),
        .i_digits         (digits),
        .i_dp             (dp),
        .i_hex            (hex),
        .i_lz_blank       (lz),
        .i_brightness     (bright),
        .i_load           (load),
        .o_segments_drive (seg),
        .o_dp_drive       (dpo),
        .o_displays_neg   (neg),
        .o_frame_start    (fs)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    logic [6:0] glyph_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model: cnt is position in the 640-cycle superframe
    // (10 ticks x 4 slots x 16 pwm frames).
    int          cnt;
    bit          valid;
    logic [15:0] a_dig, p_dig;
    logic [3:0]  a_dp, p_dp;
    logic        a_hex, p_hex, a_lz, p_lz;
    logic [3:0]  a_bri, p_bri;
    bit          p_flag;

    function automatic logic [12:0] model_out();
        int          t, s, pw;
        logic [15:0] sh;
        logic [3:0]  code;
        logic [3:0]  n;
        logic [6:0]  g;
        bit          lit, blanked, en;
        if (!valid) return {4'hF, 7'd0, 1'b0, 1'b0};
        t  = cnt % 10;
        s  = (cnt / 10) % 4;
        pw = cnt / 40;
        lit     = (a_bri == 4'hF) || (pw < int'(a_bri));
        sh      = a_dig >> (4 * s);
        code    = sh[3:0];
        blanked = a_lz && (s >= 1) && (sh == 16'h0);
        en      = lit && (t >= 2) && !blanked;
        n = 4'hF;
        if (en) n[s] = 1'b0;
        g = (code > 4'd9 && !a_hex) ? 7'd0 : glyph_tbl[code];
        return {n, en ? g : 7'd0, en && a_dp[s], (t == 0) && (s == 0)};
    endfunction

    task automatic advance();
        bit boundary;
        @(posedge clk);
        if (!rst_n) begin
            cnt = 639; valid = 0; p_flag = 0;
            a_dig = 0; a_dp = 0; a_hex = 0; a_lz = 0; a_bri = 0;
            p_dig = 0; p_dp = 0; p_hex = 0; p_lz = 0; p_bri = 0;
        end else begin
            boundary = (cnt % 40) == 39;
            if (boundary) begin
                if (load) begin
                    a_dig = digits; a_dp = dp; a_hex = hex; a_lz = lz; a_bri = bright;
                end else if (p_flag) begin
                    a_dig = p_dig; a_dp = p_dp; a_hex = p_hex; a_lz = p_lz; a_bri = p_bri;
                end
            end
            if (load) begin
                p_dig = digits; p_dp = dp; p_hex = hex; p_lz = lz; p_bri = bright; p_flag = 1;
            end
            if (boundary) p_flag = 0;
            cnt   = (cnt + 1) % 640;
            valid = 1;
        end
        @(negedge clk);
    endtask

    task automatic set_data(input logic [15:0] d, input logic [3:0] p, input logic h,
                            input logic l, input logic [3:0] b);
        digits = d; dp = p; hex = h; lz = l; bright = b;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        advance();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        set_data(16'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            advance();
            checks++;
            if ({neg, seg, dpo, fs} !== 13'b1111_0000000_0_0) begin
                errors++;
                $display("FAIL reset_state got %b want %b", {neg, seg, dpo, fs}, 13'b1111_0000000_0_0);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 81; i++) begin
            advance();
            checks++;
            if ({neg, seg, dpo, fs} !== model_out()) begin
                errors++;
                $display("FAIL reset_run cnt=%0d got %b want %b", cnt, {neg, seg, dpo, fs}, model_out());
            end
            checks++;
            if (fs !== ((i % 40) == 0) || neg !== 4'hF || seg !== 7'd0) begin
                errors++;
                $display("FAIL reset_idle i=%0d got fs=%b neg=%b seg=%b want fs=%b neg=1111 seg=0",
                         i, fs, neg, seg, (i % 40) == 0);
            end
        end
    endtask

    task automatic test_basic();
        set_data(16'h1234, 4'b0001, 1'b0, 1'b0, 4'hF);
        pulse_load();
        for (int k = 0; k < 40 && (cnt % 40) != 39; k++) begin
            advance();
            checks++;
            if ({neg, seg, dpo, fs} !== model_out()) begin
                errors++;
                $display("FAIL basic_pre cnt=%0d got %b want %b", cnt, {neg, seg, dpo, fs}, model_out());
            end
        end
        for (int i = 0; i < 40; i++) begin
            advance();
            checks++;
            if ({neg, seg, dpo, fs} !== model_out()) begin
                errors++;
                $display("FAIL basic_frame cnt=%0d got %b want %b", cnt, {neg, seg, dpo, fs}, model_out());
            end
            if (i == 1) begin
                checks++;
                if (neg !== 4'b1111 || seg !== 7'd0) begin
                    errors++;
                    $display("FAIL basic_deadtime got neg=%b seg=%b want 1111 0000000", neg, seg);
                end
            end
            if (i == 2) begin
                checks++;
                if (neg !== 4'b1110 || seg !== 7'b0110011 || dpo !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_digit0 got neg=%b seg=%b dp=%b want 1110 0110011 1", neg, seg, dpo);
                end
            end
            if (i == 35) begin
                checks++;
                if (neg !== 4'b0111 || seg !== 7'b0110000 || dpo !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_digit3 got neg=%b seg=%b dp=%b want 0111 0110000 0", neg, seg, dpo);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] pats [3] = '{16'h0050, 16'h0000, 16'h0A00};
        for (int p = 0; p < 3; p++) begin
            set_data(pats[p], 4'($urandom), 1'b0, 1'b1, 4'hF);
            pulse_load();
            for (int i = 0; i < 80; i++) begin
                advance();
                checks++;
                if ({neg, seg, dpo, fs} !== model_out()) begin
                    errors++;
                    $display("FAIL lz_%0d cnt=%0d got %b want %b", p, cnt, {neg, seg, dpo, fs}, model_out());
                end
            end
        end
    endtask

    task automatic test_hex();
        for (int h = 1; h >= 0; h--) begin
            set_data(16'hABCD, 4'h0, h[0], 1'b0, 4'hF);
            pulse_load();
            for (int k = 0; k < 40 && (cnt % 40) != 39; k++) advance();
            for (int i = 0; i < 40; i++) begin
                advance();
                checks++;
                if ({neg, seg, dpo, fs} !== model_out()) begin
                    errors++;
                    $display("FAIL hex_%0d cnt=%0d got %b want %b", h, cnt, {neg, seg, dpo, fs}, model_out());
                end
                if (i == 5 || i == 35) begin
                    checks++;
                    if (seg !== (h == 0 ? 7'd0 : (i == 5 ? 7'b0111101 : 7'b1110111)) || neg === 4'hF) begin
                        errors++;
                        $display("FAIL hex_glyph h=%0d i=%0d got seg=%b neg=%b", h, i, seg, neg);
                    end
                end
            end
        end
    endtask

    task automatic test_brightness();
        logic [3:0] levels [4] = '{4'd4, 4'd0, 4'd15, 4'd9};
        int lit_frames;
        bit frame_lit;
        for (int b = 0; b < 4; b++) begin
            set_data(16'h1234, 4'h0, 1'b0, 1'b0, levels[b]);
            pulse_load();
            for (int k = 0; k < 40 && (cnt % 40) != 39; k++) advance();
            lit_frames = 0;
            for (int f = 0; f < 16; f++) begin
                frame_lit = 0;
                for (int i = 0; i < 40; i++) begin
                    advance();
                    if (neg !== 4'hF) frame_lit = 1;
                    checks++;
                    if ({neg, seg, dpo, fs} !== model_out()) begin
                        errors++;
                        $display("FAIL bright_%0d cnt=%0d got %b want %b", levels[b], cnt,
                                 {neg, seg, dpo, fs}, model_out());
                    end
                end
                if (frame_lit) lit_frames++;
            end
            checks++;
            if (lit_frames != ((levels[b] == 4'hF) ? 16 : int'(levels[b]))) begin
                errors++;
                $display("FAIL bright_frames level=%0d got %0d want %0d", levels[b], lit_frames,
                         (levels[b] == 4'hF) ? 16 : int'(levels[b]));
            end
        end
    endtask

    task automatic test_midframe_load();
        int frame;
        set_data(16'h1111, 4'h0, 1'b0, 1'b0, 4'hF);
        pulse_load();
        for (int k = 0; k < 80 && (cnt % 40) != 15; k++) advance();
        set_data(16'h2222, 4'h0, 1'b0, 1'b0, 4'hF);
        pulse_load();
        frame = 0;
        for (int i = 0; i < 60; i++) begin
            advance();
            if ((cnt % 40) == 0) frame++;
            checks++;
            if ({neg, seg, dpo, fs} !== model_out()) begin
                errors++;
                $display("FAIL midload cnt=%0d got %b want %b", cnt, {neg, seg, dpo, fs}, model_out());
            end
            if ((cnt % 40) == 25) begin
                checks++;
                if (seg !== (frame == 0 ? 7'b0110000 : 7'b1101101)) begin
                    errors++;
                    $display("FAIL midload_slot2 frame=%0d got %b", frame, seg);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        for (int k = 0; k < 40 && (cnt % 40) != 39; k++) advance();
        set_data(16'h8888, 4'hF, 1'b0, 1'b0, 4'hF);
        pulse_load();
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({neg, seg, dpo, fs} !== model_out()) begin
                errors++;
                $display("FAIL bndload cnt=%0d got %b want %b", cnt, {neg, seg, dpo, fs}, model_out());
            end
            if (i == 2) begin
                checks++;
                if (seg !== 7'b1111111 || dpo !== 1'b1 || neg !== 4'b1110) begin
                    errors++;
                    $display("FAIL bndload_immediate got seg=%b dp=%b neg=%b want 1111111 1 1110", seg, dpo, neg);
                end
            end
            advance();
        end
    endtask

    task automatic test_double_load();
        for (int k = 0; k < 40 && (cnt % 40) != 5; k++) advance();
        set_data(16'h3333, 4'h0, 1'b0, 1'b0, 4'hF);
        pulse_load();
        advance();
        set_data(16'h4444, 4'h0, 1'b0, 1'b0, 4'hF);
        pulse_load();
        for (int k = 0; k < 40 && (cnt % 40) != 39; k++) advance();
        for (int i = 0; i < 40; i++) begin
            advance();
            checks++;
            if ({neg, seg, dpo, fs} !== model_out()) begin
                errors++;
                $display("FAIL dblload cnt=%0d got %b want %b", cnt, {neg, seg, dpo, fs}, model_out());
            end
            if (i == 3) begin
                checks++;
                if (seg !== 7'b0110011) begin
                    errors++;
                    $display("FAIL dblload_last_wins got %b want 0110011", seg);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        set_data(16'h5678, 4'hF, 1'b0, 1'b0, 4'hF);
        pulse_load();
        for (int k = 0; k < 80 && (cnt % 40) != 25; k++) advance();
        rst_n = 1'b0;
        advance();
        checks++;
        if ({neg, seg, dpo, fs} !== 13'b1111_0000000_0_0) begin
            errors++;
            $display("FAIL midreset_dark got %b want %b", {neg, seg, dpo, fs}, 13'b1111_0000000_0_0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 45; i++) begin
            advance();
            checks++;
            if ({neg, seg, dpo, fs} !== model_out() || (i == 0 && fs !== 1'b1) || neg !== 4'hF) begin
                errors++;
                $display("FAIL midreset_after i=%0d got %b want %b", i, {neg, seg, dpo, fs}, model_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            set_data(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom));
            if ($urandom_range(0, 3) == 0) digits[15:8] = 8'h00;
            load = ($urandom_range(0, 7) == 0);
            advance();
            checks++;
            if ({neg, seg, dpo, fs} !== model_out()) begin
                errors++;
                $display("FAIL random cnt=%0d got %b want %b", cnt, {neg, seg, dpo, fs}, model_out());
            end
        end
        rst_n = 1'b1;
        load  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_hex();
        test_brightness();
        test_midframe_load();
        test_boundary_load();
        test_double_load();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
